mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 255; meaning: cycles in REQ before timeout (1..255).
REQ-002 SHALL have ports: CLK in 1 clock; nRST in 1 async active-low reset.
REQ-003 SHALL have ports (from execute/memory latch): dREN_i in 1 load; dWEN_i in 1 store; addr_i in 32 ALU address; wdat_i in 32 store data; datomic_i in 1 LR (with dREN_i) or SC (with dWEN_i); flush_i in 1 squash.
REQ-004 SHALL have ports (cache side): dmemREN out 1; dmemWEN out 1; dmemaddr out 32; dmemstore out 32; dhit in 1; dmemload in 32; ccinv_i in 1 snoop invalidate; ccaddr_i in 32 snoop address.
REQ-005 SHALL have ports (pipeline side): stall_o out 1 freeze upstream; done_o out 1 access complete; ldata_o out 32 load/SC result; err_o out 1 sticky timeout.

Function
REQ-006 SHALL implement FSM IDLE, REQ, DONE, ERR.
REQ-007 In IDLE, SHALL go to REQ when (dREN_i|dWEN_i) & ~flush_i, latching addr_i, wdat_i, direction and datomic_i.
REQ-008 In IDLE with a pending request, SHALL hold stall_o=1 that cycle.
REQ-009 In REQ, SHALL drive dmemREN/dmemWEN per latched direction, with dmemaddr and dmemstore from latched values; stall_o=1.
REQ-010 In REQ on dhit, SHALL capture dmemload into ldata_o (loads only) and go to DONE; access latency is 2 cycles minimum.
REQ-011 In DONE, SHALL pulse done_o=1 for exactly one cycle, stall_o=0, drive no request, and go to IDLE.
REQ-012 In REQ, SHALL count cycles with an 8-bit counter cleared on REQ entry; on reaching MAX_WAIT without dhit, SHALL go to ERR.
REQ-013 In ERR, SHALL hold err_o=1, stall_o=1 and no request until reset.
REQ-014 flush_i in REQ on a load without dhit SHALL abort to IDLE with no done_o; flush_i SHALL be ignored for stores once in REQ.
REQ-015 dhit and flush_i in the same REQ cycle SHALL complete normally; the hit takes priority.
REQ-016 ldata_o SHALL hold its value until the next completing load or SC.

Reset
REQ-017 On nRST low, SHALL go to IDLE asynchronously; all outputs 0; counter, latched registers and link state cleared.
REQ-018 Reset asserted mid-REQ SHALL drop dmemREN/dmemWEN immediately.

Configuration
REQ-019 With MEM_LRSC_EN defined, SHALL keep a link register (valid + 32-bit address).
REQ-020 With MEM_LRSC_EN, LR completion SHALL set the link to the load address.
REQ-021 With MEM_LRSC_EN, an SC with valid link and matching address SHALL perform the write and return ldata_o=0.
REQ-022 With MEM_LRSC_EN, an SC on a mismatched or invalid link SHALL issue no write, go IDLE->DONE directly, and return ldata_o=1.
REQ-023 With MEM_LRSC_EN, any SC SHALL clear the link.
REQ-024 With MEM_LRSC_EN, ccinv_i with ccaddr_i equal to the link address SHALL clear the link, with priority over a same-cycle LR set.
REQ-025 Without MEM_LRSC_EN, datomic_i, ccinv_i and ccaddr_i SHALL be ignored; LR/SC SHALL behave as plain load/store; no link register SHALL be present.

Structure
REQ-026 The FSM state enum and the SC result constants (SC_OK=0, SC_FAIL=1) SHALL reside in cpu_types_pkg.
REQ-027 The link register logic SHALL be the sub-module mem_link_reg, instantiated only under MEM_LRSC_EN.

Verification
REQ-028 Load addr 0x100, dhit on 2nd REQ cycle, dmemload 0xDEADBEEF -> done_o at cycle 4, ldata_o=0xDEADBEEF, stall_o high cycles 1-3.
REQ-029 Store addr 0x200, wdat 0x12345678, dhit 1st REQ cycle -> dmemWEN=1 with dmemstore=0x12345678 one cycle, done_o pulse, ldata_o unchanged.
REQ-030 MAX_WAIT=4, load with no dhit -> ERR after 4 REQ cycles, err_o and stall_o stay 1.
REQ-031 Load in REQ, flush_i=1 and dhit=0 -> IDLE next cycle, no done_o; repeat with dhit=1 -> completes.
REQ-032 MEM_LRSC_EN: LR 0x300, then SC 0x300 -> write issued, ldata_o=0; LR 0x300, ccinv_i with ccaddr_i=0x300, SC 0x300 -> no write, ldata_o=1.
REQ-033 Reset asserted in REQ -> dmemREN drops the same cycle, all outputs 0, FSM IDLE.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the memory stage: FSM encoding, latched request record, SC result codes.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } mem_state_t;

    typedef struct packed {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdat;
    } mem_req_t;

    localparam logic [31:0] SC_OK   = 32'd0;
    localparam logic [31:0] SC_FAIL = 32'd1;

endpackage

// File: rtl/mem_link_reg.sv
// LR/SC reservation: one valid bit plus the reserved word address.
// A matching snoop invalidate beats a same-cycle LR set.
module mem_link_reg (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        set_i,
    input  logic [31:0] set_addr_i,
    input  logic        clr_i,
    input  logic        inv_i,
    input  logic [31:0] inv_addr_i,
    output logic        valid_o,
    output logic [31:0] addr_o
);
    logic        valid_q;
    logic [31:0] addr_q;
    logic        inv_hit;

    // Match the live link or the address about to be linked this cycle.
    assign inv_hit = inv_i & ((valid_q & (addr_q == inv_addr_i)) |
                              (set_i & (set_addr_i == inv_addr_i)));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
        end else if (inv_hit) begin
            valid_q <= 1'b0;
        end else if (set_i) begin
            valid_q <= 1'b1;
            addr_q  <= set_addr_i;
        end else if (clr_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;

endmodule

// File: rtl/mem_stage.sv
// Memory stage: single outstanding load/store to the data cache with timeout.
// Optional LR/SC support is compiled in with MEM_LRSC_EN.
module mem_stage
    import cpu_types_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dREN_i,
    input  logic        dWEN_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdat_i,
    input  logic        datomic_i,
    input  logic        flush_i,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    input  logic        dhit,
    input  logic [31:0] dmemload,
    input  logic        ccinv_i,
    input  logic [31:0] ccaddr_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] ldata_o,
    output logic        err_o
);
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    mem_state_t  state, nxt_state;
    mem_req_t    req_q;
    logic [7:0]  wait_cnt;
    logic [31:0] ldata_q, ld_nxt;
    logic        ld_cap;
    logic        pend;

    assign pend = (dREN_i | dWEN_i) & ~flush_i;

`ifdef MEM_LRSC_EN
    logic        atom_q;
    logic        lr_done, sc_done, sc_fail;
    logic        link_valid;
    logic [31:0] link_addr;

    // SC that cannot succeed is resolved in IDLE without touching the cache.
    assign sc_fail = dWEN_i & ~dREN_i & datomic_i &
                     ~(link_valid & (link_addr == addr_i));

    mem_link_reg u_link (
        .CLK        (CLK),
        .nRST       (nRST),
        .set_i      (lr_done),
        .set_addr_i (req_q.addr),
        .clr_i      (sc_done),
        .inv_i      (ccinv_i),
        .inv_addr_i (ccaddr_i),
        .valid_o    (link_valid),
        .addr_o     (link_addr)
    );
`else
    logic unused_atomic;
    assign unused_atomic = ^{datomic_i, ccinv_i, ccaddr_i};
`endif

    always_comb begin
        nxt_state = state;
        stall_o   = 1'b0;
        done_o    = 1'b0;
        dmemREN   = 1'b0;
        dmemWEN   = 1'b0;
        ld_cap    = 1'b0;
        ld_nxt    = dmemload;
`ifdef MEM_LRSC_EN
        lr_done   = 1'b0;
        sc_done   = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (pend) begin
                    stall_o   = 1'b1;
                    nxt_state = REQ;
`ifdef MEM_LRSC_EN
                    if (sc_fail) begin
                        nxt_state = DONE;
                        ld_cap    = 1'b1;
                        ld_nxt    = SC_FAIL;
                        sc_done   = 1'b1;
                    end
`endif
                end
            end
            REQ: begin
                stall_o = 1'b1;
                dmemREN = ~req_q.wen;
                dmemWEN = req_q.wen;
                // A hit wins over a same-cycle flush or timeout.
                if (dhit) begin
                    nxt_state = DONE;
                    ld_cap    = ~req_q.wen;
`ifdef MEM_LRSC_EN
                    if (atom_q) begin
                        if (req_q.wen) begin
                            ld_cap  = 1'b1;
                            ld_nxt  = SC_OK;
                            sc_done = 1'b1;
                        end else begin
                            lr_done = 1'b1;
                        end
                    end
`endif
                end else if (flush_i && !req_q.wen) begin
                    nxt_state = IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    nxt_state = ERR;
                end
            end
            DONE: begin
                done_o    = 1'b1;
                nxt_state = IDLE;
            end
            ERR: begin
                stall_o = 1'b1;
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            req_q    <= '0;
            wait_cnt <= '0;
            ldata_q  <= '0;
`ifdef MEM_LRSC_EN
            atom_q   <= 1'b0;
`endif
        end else begin
            state <= nxt_state;
            if (state == IDLE && pend) begin
                req_q.wen  <= dWEN_i & ~dREN_i;
                req_q.addr <= addr_i;
                req_q.wdat <= wdat_i;
`ifdef MEM_LRSC_EN
                atom_q     <= datomic_i;
`endif
            end
            // Held at zero while idle so every REQ entry starts from zero.
            if (state == IDLE)
                wait_cnt <= '0;
            else if (state == REQ)
                wait_cnt <= wait_cnt + 8'd1;
            if (ld_cap)
                ldata_q <= ld_nxt;
        end
    end

    assign dmemaddr  = req_q.addr;
    assign dmemstore = req_q.wdat;
    assign ldata_o   = ldata_q;
    assign err_o     = (state == ERR);

endmodule
